// File: rtl/sram_arbiter.sv
// Round-robin arbiter and strobe sequencer sharing one async SRAM between a fetch port (M0) and a data port (M1).
// Latency: grant at the sampling edge, ACCESS next cycle, ack (with read data) in the cycle after; one access per 3 cycles.
// Backpressure: requesters hold req until their one-cycle ack; requests arriving during ACCESS/DONE wait for the next IDLE edge.
module sram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              grant
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    // Access attributes latched at grant time; the address lives directly in ram_addr.
    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] wdata;
    } acc_t;

    state_t state;
    acc_t   acc_q;
    logic   last;      // port of the most recent grant: 0 = M0, 1 = M1
    logic   drive_q;   // bus output enable, held through DONE for write hold time
    logic   any_req;
    logic   pick_m1;

    // Round-robin choice: a lone requester wins; on a tie the port that did not win last time wins.
    always_comb begin
        any_req = m0_req | m1_req;
        pick_m1 = m1_req & (~m0_req | ~last);
    end

    // The data bus is driven only while a write is in ACCESS or DONE.
    assign ram_data = drive_q ? acc_q.wdata : {DATA_W{1'bz}};

    // Access sequencer: IDLE -> ACCESS -> DONE -> IDLE, with every pin and ack registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            grant    <= 1'b0;
            acc_q    <= '0;
            drive_q  <= 1'b0;
            ram_addr <= '0;
            ram_ce_n <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_we_n <= 1'b1;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state    <= ACCESS;
                        grant    <= pick_m1;
                        last     <= pick_m1;
                        ram_addr <= pick_m1 ? m1_addr : m0_addr;
                        acc_q.we <= pick_m1 & m1_we;
                        if (pick_m1) begin
                            acc_q.wdata <= m1_wdata;
                        end
                        ram_ce_n <= 1'b0;
                        // M0 is fetch-only, so only an M1 write drops WE and drives the bus.
                        if (pick_m1 && m1_we) begin
                            ram_we_n <= 1'b0;
                            drive_q  <= 1'b1;
                        end else begin
                            ram_oe_n <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    state    <= DONE;
                    ram_we_n <= 1'b1;
                    ram_oe_n <= 1'b1;
                    // Read data is sampled while OE is still low, then held until that port's next read.
                    if (!acc_q.we) begin
                        if (grant) begin
                            m1_rdata <= ram_data;
                        end else begin
                            m0_rdata <= ram_data;
                        end
                    end
                    if (grant) begin
                        m1_ack <= 1'b1;
                    end else begin
                        m0_ack <= 1'b1;
                    end
                end
                DONE: begin
                    // Always pass through IDLE so a requester's stale req is never granted twice.
                    state    <= IDLE;
                    m0_ack   <= 1'b0;
                    m1_ack   <= 1'b0;
                    ram_ce_n <= 1'b1;
                    drive_q  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req;
    logic [AW-1:0] m0_addr;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;
    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;
    logic          ram_ce_n;
    logic          ram_oe_n;
    logic          ram_we_n;
    logic          grant;

    int n_tests = 0;
    int n_fail  = 0;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
        .grant(grant)
    );

    initial forever #5 clk = ~clk;

    // Behavioural asynchronous SRAM: drives the bus while CE and OE are low, stores on clock edges while WE is low.
    logic [DW-1:0] sram [0:65535];
    logic          sram_load;
    logic          sram_oe;
    assign sram_oe  = !ram_ce_n && !ram_oe_n;
    assign ram_data = sram_oe ? sram[ram_addr] : {DW{1'bz}};

    always @(posedge clk) begin
        if (sram_load) begin
            for (int i = 0; i < 65536; i++) sram[i] <= '0;
            sram[16'h0040] <= 16'h1234;
            sram[16'hFFFF] <= 16'hCAFE;
        end else if (!ram_ce_n && !ram_we_n) begin
            sram[ram_addr] <= ram_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Protocol invariants watched every cycle outside reset.
    logic prev_we_n = 1'b1;
    always @(negedge clk) begin
        if (!rst) begin
            chk("acks_exclusive", {31'd0, m0_ack & m1_ack}, 32'd0);
            chk("we_low_one_cycle", {31'd0, !prev_we_n && !ram_we_n}, 32'd0);
        end
        prev_we_n = ram_we_n;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // Single-port transaction from IDLE, checked cycle by cycle.
    task automatic do_txn(input logic p, input logic we, input logic [15:0] a,
                          input logic [15:0] wd, input logic [15:0] exp_rd);
        logic wr;
        wr = p && we;
        if (p) begin
            m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = wd;
        end else begin
            m0_req = 1'b1; m0_addr = a;
        end
        step();
        chk("acc_ce_n", {31'd0, ram_ce_n}, 32'd0);
        chk("acc_addr", {16'd0, ram_addr}, {16'd0, a});
        chk("acc_we_n", {31'd0, ram_we_n}, {31'd0, !wr});
        chk("acc_oe_n", {31'd0, ram_oe_n}, {31'd0, wr});
        chk("acc_grant", {31'd0, grant}, {31'd0, p});
        chk("acc_no_ack", {31'd0, m0_ack | m1_ack}, 32'd0);
        if (wr) chk("acc_bus", {16'd0, ram_data}, {16'd0, wd});
        step();
        chk("done_m0_ack", {31'd0, m0_ack}, {31'd0, !p});
        chk("done_m1_ack", {31'd0, m1_ack}, {31'd0, p});
        chk("done_we_n", {31'd0, ram_we_n}, 32'd1);
        chk("done_oe_n", {31'd0, ram_oe_n}, 32'd1);
        chk("done_ce_n", {31'd0, ram_ce_n}, 32'd0);
        if (wr) chk("done_bus_hold", {16'd0, ram_data}, {16'd0, wd});
        else if (p) chk("done_m1_rdata", {16'd0, m1_rdata}, {16'd0, exp_rd});
        else chk("done_m0_rdata", {16'd0, m0_rdata}, {16'd0, exp_rd});
        m0_req = 1'b0;
        m1_req = 1'b0;
        step();
        chk("idle_no_ack", {31'd0, m0_ack | m1_ack}, 32'd0);
        chk("idle_ce_n", {31'd0, ram_ce_n}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;
    vec_t vecs [9];

    // Reference model state for the randomized phase.
    logic [15:0] ref_mem [logic [15:0]];
    int          ack_cyc [2];
    logic        pend_is_rd [2];
    logic [15:0] pend_rd [2];
    logic [15:0] exp_rdata [2];
    int          free_edge;
    logic        m_last;
    logic        win;
    int          n_acks;
    int          last_c;
    logic        aport;

    function automatic logic [15:0] ref_get(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 16'h0000;
    endfunction

    initial begin
        vecs[0] = '{1'b1, 1'b1, 16'h0012, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 16'hBEEF};
        vecs[2] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h1234};
        vecs[3] = '{1'b1, 1'b1, 16'h0040, 16'h5A5A, 16'h0000};
        vecs[4] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h5A5A};
        vecs[5] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hCAFE};
        vecs[6] = '{1'b1, 1'b1, 16'h0000, 16'h0001, 16'h0000};
        vecs[7] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001};
        vecs[8] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'h5A5A};

        // Reset held two cycles with a write request pending: reset must win.
        rst = 1'b1; sram_load = 1'b1;
        m0_req = 1'b0; m0_addr = '0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0077; m1_wdata = 16'hA5A5;
        step();
        sram_load = 1'b0;
        step();
        chk("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
        chk("rst_m1_ack", {31'd0, m1_ack}, 32'd0);
        chk("rst_m0_rdata", {16'd0, m0_rdata}, 32'd0);
        chk("rst_m1_rdata", {16'd0, m1_rdata}, 32'd0);
        chk("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
        chk("rst_ce_n", {31'd0, ram_ce_n}, 32'd1);
        chk("rst_oe_n", {31'd0, ram_oe_n}, 32'd1);
        chk("rst_we_n", {31'd0, ram_we_n}, 32'd1);
        chk("rst_grant", {31'd0, grant}, 32'd0);
        chk("rst_bus_released", {31'd0, ram_data === 16'hA5A5}, 32'd0);
        m1_req = 1'b0;
        rst = 1'b0;
        step();

        for (int i = 0; i < 9; i++)
            do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

        // Tie: both ports request continuously; M0 first, then strict alternation every 3 cycles.
        do_reset();
        m0_req = 1'b1; m0_addr = 16'h0040;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0012;
        n_acks = 0; last_c = 0;
        for (int c = 0; c < 40 && n_acks < 6; c++) begin
            step();
            if (m0_ack || m1_ack) begin
                aport = m1_ack;
                chk("tie_port", {31'd0, aport}, n_acks % 2);
                if (n_acks == 0) chk("tie_first_latency", c, 1);
                else chk("tie_spacing", c - last_c, 3);
                if (aport) begin
                    chk("tie_m1_rdata", {16'd0, m1_rdata}, 32'hBEEF);
                    m1_req = 1'b0;
                end else begin
                    chk("tie_m0_rdata", {16'd0, m0_rdata}, 32'h5A5A);
                    m0_req = 1'b0;
                end
                last_c = c;
                n_acks++;
            end else begin
                m0_req = 1'b1;
                m1_req = 1'b1;
            end
        end
        chk("tie_count", n_acks, 6);
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        step();

        // Reset during the ACCESS cycle of a write aborts it without an ack.
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0033; m1_wdata = 16'hA5A5;
        step();
        chk("rmw_acc_we_n", {31'd0, ram_we_n}, 32'd0);
        rst = 1'b1; m1_req = 1'b0;
        step();
        chk("rmw_we_n", {31'd0, ram_we_n}, 32'd1);
        chk("rmw_ce_n", {31'd0, ram_ce_n}, 32'd1);
        chk("rmw_oe_n", {31'd0, ram_oe_n}, 32'd1);
        chk("rmw_no_ack", {31'd0, m1_ack}, 32'd0);
        chk("rmw_bus_released", {31'd0, ram_data === 16'hA5A5}, 32'd0);
        rst = 1'b0;
        step();
        chk("rmw_still_no_ack", {31'd0, m1_ack}, 32'd0);
        do_txn(1'b1, 1'b1, 16'h0033, 16'h1111, 16'h0000);
        do_txn(1'b1, 1'b0, 16'h0033, 16'h0000, 16'h1111);

        // Late M0 request during M1's ACCESS waits for the IDLE edge after M1's DONE.
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0012;
        step();
        m0_req = 1'b1; m0_addr = 16'h0040;
        step();
        chk("late_m1_ack", {31'd0, m1_ack}, 32'd1);
        chk("late_m0_no_ack", {31'd0, m0_ack}, 32'd0);
        chk("late_m1_rdata", {16'd0, m1_rdata}, 32'hBEEF);
        m1_req = 1'b0;
        step();
        chk("late_idle_ce_n", {31'd0, ram_ce_n}, 32'd1);
        chk("late_idle_grant", {31'd0, grant}, 32'd1);
        step();
        chk("late_m0_grant", {31'd0, grant}, 32'd0);
        chk("late_m0_addr", {16'd0, ram_addr}, 32'h0040);
        chk("late_m0_oe_n", {31'd0, ram_oe_n}, 32'd0);
        step();
        chk("late_m0_ack", {31'd0, m0_ack}, 32'd1);
        chk("late_m0_rdata", {16'd0, m0_rdata}, 32'h5A5A);
        chk("late_m1_rdata_held", {16'd0, m1_rdata}, 32'hBEEF);
        m0_req = 1'b0;
        step();
        chk("late_m1_rdata_kept", {16'd0, m1_rdata}, 32'hBEEF);

        // Randomized traffic against a transaction-level model: one grant per 3 cycles, ack 2 cycles after grant.
        do_reset();
        m_last = 1'b1;
        free_edge = 0;
        ack_cyc[0] = -10; ack_cyc[1] = -10;
        pend_is_rd[0] = 1'b0; pend_is_rd[1] = 1'b0;
        pend_rd[0] = '0; pend_rd[1] = '0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        for (int k = 0; k < 3000; k++) begin
            for (int p = 0; p < 2; p++)
                if (ack_cyc[p] == k && pend_is_rd[p]) exp_rdata[p] = pend_rd[p];
            chk("rnd_m0_ack", {31'd0, m0_ack}, {31'd0, ack_cyc[0] == k});
            chk("rnd_m1_ack", {31'd0, m1_ack}, {31'd0, ack_cyc[1] == k});
            chk("rnd_m0_rdata", {16'd0, m0_rdata}, {16'd0, exp_rdata[0]});
            chk("rnd_m1_rdata", {16'd0, m1_rdata}, {16'd0, exp_rdata[1]});
            if (ack_cyc[0] == k) m0_req = 1'b0;
            else if (!m0_req && $urandom_range(0, 3) != 0) begin
                m0_req = 1'b1;
                m0_addr = 16'h0200 + 16'($urandom_range(0, 15));
            end
            if (ack_cyc[1] == k) m1_req = 1'b0;
            else if (!m1_req && $urandom_range(0, 3) != 0) begin
                m1_req = 1'b1;
                m1_we = 1'($urandom_range(0, 1));
                m1_addr = 16'h0200 + 16'($urandom_range(0, 15));
                m1_wdata = 16'($urandom);
            end
            if (k + 1 >= free_edge && (m0_req || m1_req)) begin
                if (m0_req && m1_req) win = !m_last;
                else win = m1_req;
                m_last = win;
                ack_cyc[win] = k + 2;
                free_edge = k + 4;
                if (win && m1_we) begin
                    ref_mem[m1_addr] = m1_wdata;
                    pend_is_rd[1] = 1'b0;
                end else begin
                    pend_is_rd[win] = 1'b1;
                    pend_rd[win] = ref_get(win ? m1_addr : m0_addr);
                end
            end
            @(negedge clk);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        step();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
